// File: rtl/ddfs_freq_meter.sv
// Period meter for DDFS sine output: hysteretic rising zero-crossing detector
// feeding a cycle counter that times 2**LOG2_NPER consecutive periods.
module ddfs_freq_meter #(
  parameter int NBIT_SAMPLE = 12,
  parameter int NBIT_CNT    = 24,
  parameter int LOG2_NPER   = 2,
  parameter int HYST        = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              sample_valid,
  input  logic signed [NBIT_SAMPLE-1:0]     sample,
  output logic                              busy,
  output logic                              valid,
  output logic                              timeout,
  output logic [NBIT_CNT-1:0]               total_cnt,
  output logic [NBIT_CNT-LOG2_NPER-1:0]     period_cnt
);

  localparam int NPER = 1 << LOG2_NPER;
  localparam int XW   = LOG2_NPER + 1;
  localparam logic [NBIT_CNT-1:0]           CNT_MAX  = '1;
  localparam logic [XW-1:0]                 LAST_X   = XW'(NPER - 1);
  localparam logic signed [NBIT_SAMPLE-1:0] POS_THR  = NBIT_SAMPLE'(HYST);
  localparam logic signed [NBIT_SAMPLE-1:0] NEG_THR  = NBIT_SAMPLE'(-HYST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                          state, state_nxt;
  logic [NBIT_CNT-1:0]             cnt, cnt_nxt, cnt_inc;
  logic [XW-1:0]                   xcnt, xcnt_nxt;
  logic                            neg_flag, neg_flag_nxt;
  logic                            valid_nxt, timeout_nxt;
  logic [NBIT_CNT-1:0]             total_nxt;
  logic [NBIT_CNT-LOG2_NPER-1:0]   period_nxt;
  logic                            is_neg, is_pos, rise, sat_hit;

  // Crossing detector: a rise needs a prior excursion below -HYST.
  assign is_neg = sample_valid && (sample < NEG_THR);
  assign is_pos = sample_valid && (sample >= POS_THR);
  assign rise   = neg_flag && is_pos;

  // Counter saturates at all-ones; reaching it is the timeout condition.
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + NBIT_CNT'(1);
  assign sat_hit = (cnt_inc == CNT_MAX);

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    xcnt_nxt     = xcnt;
    valid_nxt    = 1'b0;
    timeout_nxt  = 1'b0;
    total_nxt    = total_cnt;
    period_nxt   = period_cnt;
    neg_flag_nxt = neg_flag;
    if (is_neg) begin
      neg_flag_nxt = 1'b1;
    end else if (rise) begin
      neg_flag_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = ARM;
          cnt_nxt      = '0;
          xcnt_nxt     = '0;
          neg_flag_nxt = 1'b0;
        end
      end
      ARM: begin
        if (rise) begin
          state_nxt = MEASURE;
          cnt_nxt   = '0;
          xcnt_nxt  = '0;
        end else if (sat_hit) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
          cnt_nxt     = cnt_inc;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      MEASURE: begin
        cnt_nxt = cnt_inc;
        if (rise) begin
          xcnt_nxt = xcnt + XW'(1);
        end
        // The closing rise wins over saturation when both land on one edge.
        if (rise && (xcnt == LAST_X)) begin
          state_nxt  = IDLE;
          valid_nxt  = 1'b1;
          total_nxt  = cnt_inc;
          period_nxt = (NBIT_CNT-LOG2_NPER)'(cnt_inc >> LOG2_NPER);
        end else if (sat_hit) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      xcnt       <= '0;
      neg_flag   <= 1'b0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      total_cnt  <= '0;
      period_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      xcnt       <= xcnt_nxt;
      neg_flag   <= neg_flag_nxt;
      valid      <= valid_nxt;
      timeout    <= timeout_nxt;
      total_cnt  <= total_nxt;
      period_cnt <= period_nxt;
    end
  end

endmodule

// File: tb/tb_ddfs_freq_meter.sv
// Directed bench for ddfs_freq_meter: default instance plus an 8-bit-counter
// instance (timeout) and a single-period instance (LOG2_NPER=0).
module tb_ddfs_freq_meter;

  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start8, start0;
  logic sample_valid;
  logic signed [11:0] sample;

  logic        busy, valid, timeout;
  logic [23:0] total_cnt;
  logic [21:0] period_cnt;
  logic        busy8, valid8, timeout8;
  logic [7:0]  total_cnt8;
  logic [5:0]  period_cnt8;
  logic        busy0, valid0, timeout0;
  logic [23:0] total_cnt0;
  logic [23:0] period_cnt0;

  int checks = 0;
  int failures = 0;

  int tick = 0;
  int per = 100;
  int amp = 1000;
  int vdiv = 1;
  bit noise = 1'b0;

  ddfs_freq_meter u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .sample(sample), .busy(busy), .valid(valid), .timeout(timeout),
    .total_cnt(total_cnt), .period_cnt(period_cnt)
  );

  ddfs_freq_meter #(.NBIT_CNT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sample_valid(sample_valid),
    .sample(sample), .busy(busy8), .valid(valid8), .timeout(timeout8),
    .total_cnt(total_cnt8), .period_cnt(period_cnt8)
  );

  ddfs_freq_meter #(.LOG2_NPER(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sample_valid(sample_valid),
    .sample(sample), .busy(busy0), .valid(valid0), .timeout(timeout0),
    .total_cnt(total_cnt0), .period_cnt(period_cnt0)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Advance one clock; returns at the falling edge with the next sample applied.
  task automatic tone_cycle();
    int ph;
    int s;
    @(negedge clk);
    ph = tick % per;
    s = $rtoi(real'(amp) * $sin(2.0 * PI * real'(ph) / real'(per)));
    if (noise) s = s + int'($urandom_range(10)) - 5;
    sample = 12'(s);
    sample_valid = ((tick % vdiv) == 0);
    tick++;
  endtask

  task automatic set_tone(input int p, input int a, input int d, input bit n);
    per = p; amp = a; vdiv = d; noise = n; tick = 0;
    for (int i = 0; i < 5; i++) tone_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start8 = 1'b0; start0 = 1'b0;
    sample_valid = 1'b0; sample = '0;
    for (int i = 0; i < 3; i++) tone_cycle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if (total_cnt !== 24'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total_cnt); end
    checks++; if (period_cnt !== 22'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period_cnt); end
    rst_n = 1'b1;
    tone_cycle();
  endtask

  // Full measurement on the default instance, with a start poke while busy.
  task automatic measure(input string name, input int p, input int d, input bit n,
                         input int exp_total, input int exp_period);
    bit got_v, got_t, busy_at_v;
    int nv;
    set_tone(p, 1000, d, n);
    start = 1'b1;
    tone_cycle();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy_after_start got=%b exp=1", name, busy); end
    got_v = 1'b0; got_t = 1'b0; busy_at_v = 1'b1;
    for (int c = 1; c < 3000 && !got_v && !got_t; c++) begin
      if (c == 150) start = 1'b1;
      tone_cycle();
      start = 1'b0;
      got_v = valid; got_t = timeout; busy_at_v = busy;
    end
    checks++; if (got_v !== 1'b1) begin failures++; $display("FAIL %s_valid_seen got=%b exp=1 (timeout=%b)", name, got_v, got_t); end
    checks++; if (busy_at_v !== 1'b0) begin failures++; $display("FAIL %s_busy_with_valid got=%b exp=0", name, busy_at_v); end
    checks++; if (total_cnt !== 24'(exp_total)) begin failures++; $display("FAIL %s_total got=%0d exp=%0d", name, total_cnt, exp_total); end
    checks++; if (period_cnt !== 22'(exp_period)) begin failures++; $display("FAIL %s_period got=%0d exp=%0d", name, period_cnt, exp_period); end
    nv = 0;
    for (int c = 0; c < 300; c++) begin
      tone_cycle();
      if (valid || busy) nv++;
    end
    checks++; if (nv !== 0) begin failures++; $display("FAIL %s_stays_idle got=%0d exp=0", name, nv); end
  endtask

  task automatic test_back_to_back();
    bit got_v;
    set_tone(100, 1000, 1, 1'b0);
    start = 1'b1;
    tone_cycle();
    start = 1'b0;
    got_v = 1'b0;
    for (int c = 0; c < 3000 && !got_v; c++) begin
      tone_cycle();
      got_v = valid;
    end
    checks++; if (got_v !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", got_v); end
    start = 1'b1;
    tone_cycle();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_start_on_valid got=%b exp=1", busy); end
    got_v = 1'b0;
    for (int c = 0; c < 3000 && !got_v; c++) begin
      tone_cycle();
      got_v = valid;
    end
    checks++; if (got_v !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", got_v); end
    checks++; if (total_cnt !== 24'd400) begin failures++; $display("FAIL b2b_total got=%0d exp=400", total_cnt); end
  endtask

  task automatic test_timeout();
    int c;
    bit got_t;
    int nv;
    set_tone(100, 0, 1, 1'b0);
    start8 = 1'b1;
    tone_cycle();
    start8 = 1'b0;
    c = 0; got_t = 1'b0; nv = 0;
    while (c < 600 && !got_t) begin
      tone_cycle();
      c++;
      got_t = timeout8;
      if (valid8) nv++;
    end
    checks++; if (got_t !== 1'b1) begin failures++; $display("FAIL to_seen got=%b exp=1", got_t); end
    checks++; if (c !== 255) begin failures++; $display("FAIL to_latency got=%0d exp=255", c); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", busy8); end
    checks++; if (total_cnt8 !== 8'd0) begin failures++; $display("FAIL to_total got=%0d exp=0", total_cnt8); end
    checks++; if (nv !== 0) begin failures++; $display("FAIL to_no_valid got=%0d exp=0", nv); end
    tone_cycle();
    checks++; if (timeout8 !== 1'b0) begin failures++; $display("FAIL to_one_cycle got=%b exp=0", timeout8); end
  endtask

  task automatic test_single_period();
    bit got_v;
    set_tone(38, 1000, 1, 1'b0);
    start0 = 1'b1;
    tone_cycle();
    start0 = 1'b0;
    got_v = 1'b0;
    for (int c = 0; c < 1000 && !got_v; c++) begin
      tone_cycle();
      got_v = valid0;
    end
    checks++; if (got_v !== 1'b1) begin failures++; $display("FAIL p38_valid got=%b exp=1", got_v); end
    checks++; if (total_cnt0 !== 24'd38) begin failures++; $display("FAIL p38_total got=%0d exp=38", total_cnt0); end
    checks++; if (period_cnt0 !== 24'd38) begin failures++; $display("FAIL p38_period got=%0d exp=38", period_cnt0); end
  endtask

  task automatic test_mid_reset();
    int bad;
    set_tone(100, 1000, 1, 1'b0);
    start = 1'b1;
    tone_cycle();
    start = 1'b0;
    for (int c = 0; c < 250; c++) tone_cycle();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mr_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", busy); end
    checks++; if (total_cnt !== 24'd0) begin failures++; $display("FAIL mr_total got=%0d exp=0", total_cnt); end
    checks++; if (period_cnt !== 22'd0) begin failures++; $display("FAIL mr_period got=%0d exp=0", period_cnt); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tone_cycle();
      if (valid || timeout) bad++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tone_cycle();
      if (valid || timeout) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL mr_no_pulse got=%0d exp=0", bad); end
    measure("mr_again", 100, 1, 1'b0, 400, 100);
  endtask

  initial begin
    test_reset();
    measure("ideal", 100, 1, 1'b0, 400, 100);
    measure("half_valid", 100, 2, 1'b0, 400, 100);
    measure("noisy", 100, 1, 1'b1, 400, 100);
    measure("p37", 37, 1, 1'b0, 148, 37);
    test_single_period();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
